// File: rtl/washer_pkg.sv
// Shared washer definitions: phase encoding and pass-count clamping.
// Latency: none, declarations only.
// Backpressure: not applicable.
package washer_pkg;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_FILL  = 3'd1,
    PH_WASH  = 3'd2,
    PH_RINSE = 3'd3,
    PH_SPIN  = 3'd4
  } phase_t;

  localparam int PHASE_W = 3;

  // A request of 0 still runs one pass; anything above the maximum saturates.
  function automatic int clamp_passes(input int req, input int max_passes);
    if (req < 1) return 1;
    if (req > max_passes) return max_passes;
    return req;
  endfunction

endpackage

// File: rtl/washer_tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV un-held cycles.
// Latency: tick is decoded from the count register, same cycle as the last count.
// Backpressure: hold freezes the count and masks tick; clr wins over hold.
module washer_tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..TICK_DIV-1 and wrap; clear and hold gate the advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!hold) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST) && !hold;

endmodule

// File: rtl/wash_program_controller.sv
// Washer sequencer: FILL, WASH/RINSE x passes, SPIN, timed in seconds via a prescaler.
// Latency: coin accepted at edge N gives FILL after edge N; all outputs registered.
// Backpressure: pause freezes every counter in the same cycle; abort returns to IDLE.
module wash_program_controller
  import washer_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int SEC_W      = 16,
  parameter int FILL_S     = 120,
  parameter int WASH_S     = 300,
  parameter int RINSE_S    = 120,
  parameter int SPIN_S     = 60,
  parameter int MAX_PASSES = 4,
  localparam int PASS_W    = $clog2(MAX_PASSES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              coin_in,
  input  logic [PASS_W-1:0] wash_passes,
  input  logic              pause,
  input  logic              abort,
  output logic [2:0]        phase,
  output logic              busy,
  output logic              paused,
  output logic [PASS_W-1:0] pass_idx,
  output logic              wash_done
);

  if (TICK_DIV < 1 || MAX_PASSES < 1 || FILL_S < 1 || WASH_S < 1 ||
      RINSE_S < 1 || SPIN_S < 1) begin : g_bad_range
    $error("wash_program_controller: durations, TICK_DIV and MAX_PASSES must be >= 1");
  end

  if ((FILL_S >> SEC_W) != 0 || (WASH_S >> SEC_W) != 0 ||
      (RINSE_S >> SEC_W) != 0 || (SPIN_S >> SEC_W) != 0) begin : g_bad_width
    $error("wash_program_controller: a phase duration does not fit in SEC_W bits");
  end

  localparam logic [SEC_W-1:0] FILL_LAST  = SEC_W'(FILL_S - 1);
  localparam logic [SEC_W-1:0] WASH_LAST  = SEC_W'(WASH_S - 1);
  localparam logic [SEC_W-1:0] RINSE_LAST = SEC_W'(RINSE_S - 1);
  localparam logic [SEC_W-1:0] SPIN_LAST  = SEC_W'(SPIN_S - 1);

  phase_t            state;
  logic [SEC_W-1:0]  sec;
  logic [PASS_W-1:0] pass_q;
  logic [PASS_W-1:0] passes_q;
  logic              done_q;
  logic              paused_q;

  logic              active;
  logic              tick;
  logic [SEC_W-1:0]  cur_last;
  logic              phase_end;
  logic              presc_clr;
  logic [PASS_W:0]   pass_next_w;

  assign active      = (state != PH_IDLE);
  assign pass_next_w = {1'b0, pass_q} + {{PASS_W{1'b0}}, 1'b1};

  // Last seconds value of the phase currently running.
  always_comb begin
    cur_last = '0;
    case (state)
      PH_FILL:  cur_last = FILL_LAST;
      PH_WASH:  cur_last = WASH_LAST;
      PH_RINSE: cur_last = RINSE_LAST;
      PH_SPIN:  cur_last = SPIN_LAST;
      default:  cur_last = '0;
    endcase
  end

  // A phase only ends when nothing of higher priority is asserted.
  assign phase_end = active && !abort && !pause && tick && (sec == cur_last);

  // The prescaler sits at zero in IDLE and restarts on every phase boundary.
  assign presc_clr = !active || abort || phase_end;

  washer_tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (presc_clr),
    .hold (pause),
    .tick (tick)
  );

  // Sequencer: start/abort/pause priority, seconds counting and phase transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PH_IDLE;
      sec      <= '0;
      pass_q   <= '0;
      passes_q <= '0;
      done_q   <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      paused_q <= active && pause && !abort;
      if (!active) begin
        if (coin_in && !abort) begin
          passes_q <= PASS_W'(clamp_passes(int'(wash_passes), MAX_PASSES));
          pass_q   <= '0;
          sec      <= '0;
          done_q   <= 1'b0;
          state    <= PH_FILL;
        end
      end else if (abort) begin
        state  <= PH_IDLE;
        sec    <= '0;
        pass_q <= '0;
      end else if (!pause && tick) begin
        if (sec == cur_last) begin
          sec <= '0;
          case (state)
            PH_FILL: state <= PH_WASH;
            PH_WASH: state <= PH_RINSE;
            PH_RINSE: begin
              if (pass_next_w < {1'b0, passes_q}) begin
                pass_q <= pass_q + PASS_W'(1);
                state  <= PH_WASH;
              end else begin
                state <= PH_SPIN;
              end
            end
            PH_SPIN: begin
              state  <= PH_IDLE;
              done_q <= 1'b1;
            end
            default: state <= PH_IDLE;
          endcase
        end else begin
          sec <= sec + SEC_W'(1);
        end
      end
    end
  end

  assign phase     = state;
  assign busy      = active;
  assign paused    = paused_q;
  assign pass_idx  = pass_q;
  assign wash_done = done_q;

endmodule

// File: tb/tb_wash_program_controller.sv
// Bench for wash_program_controller with a phase-budget reference model.
// Latency: outputs checked 1 time unit after every rising edge.
// Backpressure: pause/abort exercised in directed and random scenarios.
module tb_wash_program_controller;

  localparam int TD = 4;
  localparam int FS = 2;
  localparam int WS = 3;
  localparam int RS = 2;
  localparam int SS = 1;
  localparam int MP = 3;
  localparam int PW = $clog2(MP + 1);
  localparam int LIMIT = 400;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          coin_in;
  logic [PW-1:0] wash_passes;
  logic          pause;
  logic          abort;
  logic [2:0]    phase;
  logic          busy;
  logic          paused;
  logic [PW-1:0] pass_idx;
  logic          wash_done;

  int total = 0;
  int bad   = 0;

  // Reference model: phase number plus remaining un-paused cycles in it.
  int m_state;
  int m_rem;
  int m_pass;
  int m_passes;
  bit m_done;
  bit m_paused;

  wash_program_controller #(
    .TICK_DIV(TD), .SEC_W(8), .FILL_S(FS), .WASH_S(WS),
    .RINSE_S(RS), .SPIN_S(SS), .MAX_PASSES(MP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .coin_in(coin_in), .wash_passes(wash_passes),
    .pause(pause), .abort(abort), .phase(phase), .busy(busy), .paused(paused),
    .pass_idx(pass_idx), .wash_done(wash_done)
  );

  always #5 clk = ~clk;

  wire [7:0] obs = {phase, busy, paused, pass_idx, wash_done};

  function automatic int dur_of(input int s);
    case (s)
      1: return FS * TD;
      2: return WS * TD;
      3: return RS * TD;
      4: return SS * TD;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] exp_vec();
    return {3'(m_state), (m_state != 0), m_paused, 2'(m_pass), m_done};
  endfunction

  task automatic model_reset();
    m_state = 0; m_rem = 0; m_pass = 0; m_passes = 1; m_done = 0; m_paused = 0;
  endtask

  task automatic model_go(input int s);
    m_state = s;
    m_rem   = dur_of(s);
  endtask

  task automatic model_edge(input logic c, input logic [PW-1:0] wp, input logic p, input logic a);
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_paused = (m_state != 0) && p && !a;
    if (m_state == 0) begin
      if (c && !a) begin
        m_passes = (wp == 0) ? 1 : ((int'(wp) > MP) ? MP : int'(wp));
        m_pass = 0;
        m_done = 0;
        model_go(1);
      end
    end else if (a) begin
      m_state = 0;
      m_pass  = 0;
    end else if (!p) begin
      m_rem--;
      if (m_rem == 0) begin
        case (m_state)
          1: model_go(2);
          2: model_go(3);
          3: if (m_pass < m_passes - 1) begin m_pass++; model_go(2); end
             else model_go(4);
          default: begin m_state = 0; m_done = 1; end
        endcase
      end
    end
  endtask

  task automatic step(input logic c, input logic [PW-1:0] wp, input logic p, input logic a);
    coin_in = c; wash_passes = wp; pause = p; abort = a;
    @(posedge clk);
    model_edge(c, wp, p, a);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; coin_in = 0; wash_passes = 0; pause = 0; abort = 0;
    model_reset();
    #12;
    total++;
    if (obs !== 8'h00) begin bad++; $display("FAIL reset_state: got %h expected %h", obs, 8'h00); end
    @(negedge clk); rst_n = 1'b1;
    step(0, 2, 1, 0);
    total++;
    if (obs !== exp_vec()) begin bad++; $display("FAIL idle_pause: got %h expected %h", obs, exp_vec()); end
  endtask

  task automatic test_basic();
    int cyc = 0;
    int per[8];
    foreach (per[i]) per[i] = 0;
    step(1, 1, 0, 0);
    total++;
    if (obs !== exp_vec() || phase !== 3'd1) begin bad++; $display("FAIL basic_start: got %h expected %h", obs, exp_vec()); end
    while (busy === 1'b1 && cyc < LIMIT) begin
      per[phase]++;
      step(0, 1, 0, 0); cyc++;
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL basic_cycle%0d: got %h expected %h", cyc, obs, exp_vec()); end
    end
    total++;
    if (cyc != 32 || wash_done !== 1'b1) begin bad++; $display("FAIL basic_length: got %0d done=%b expected 32 done=1", cyc, wash_done); end
    total++;
    if (per[1] != FS*TD || per[2] != WS*TD || per[3] != RS*TD || per[4] != SS*TD) begin
      bad++; $display("FAIL basic_phase_len: got %0d/%0d/%0d/%0d expected 8/12/8/4", per[1], per[2], per[3], per[4]);
    end
  endtask

  task automatic test_multi();
    int cyc = 0;
    int bump = -1;
    step(1, 2, 0, 0);
    while (busy === 1'b1 && cyc < LIMIT) begin
      step(0, 0, 0, 0); cyc++;
      if (bump < 0 && pass_idx === 2'd1) bump = cyc;
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL multi_cycle%0d: got %h expected %h", cyc, obs, exp_vec()); end
    end
    total++;
    if (bump != 28) begin bad++; $display("FAIL multi_pass_step: got cycle %0d expected 28", bump); end
    total++;
    if (cyc != 52) begin bad++; $display("FAIL multi_length: got %0d expected 52", cyc); end
  endtask

  task automatic test_clamp();
    int want[2] = '{32, 72};
    logic [PW-1:0] req[2] = '{2'd0, 2'd3};
    for (int k = 0; k < 2; k++) begin
      int cyc = 0;
      step(1, req[k], 1, 0);
      total++;
      if (obs !== exp_vec() || busy !== 1'b1) begin bad++; $display("FAIL clamp_start%0d: got %h expected %h", k, obs, exp_vec()); end
      while (busy === 1'b1 && cyc < LIMIT) begin
        step(0, 2'd2, 0, 0); cyc++;
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL clamp%0d_cycle%0d: got %h expected %h", k, cyc, obs, exp_vec()); end
      end
      total++;
      if (cyc != want[k]) begin bad++; $display("FAIL clamp_length%0d: got %0d expected %0d", k, cyc, want[k]); end
    end
  endtask

  task automatic test_pause();
    int cyc = 0;
    logic p;
    step(1, 1, 0, 0);
    while (busy === 1'b1 && cyc < LIMIT) begin
      p = (cyc == 7) || (cyc >= 13 && cyc <= 17);
      step(0, 1, p, 0); cyc++;
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL pause_cycle%0d: got %h expected %h", cyc, obs, exp_vec()); end
      if (cyc == 8) begin
        total++;
        if (phase !== 3'd1 || paused !== 1'b1) begin bad++; $display("FAIL pause_final_fill: got phase=%0d paused=%b expected 1/1", phase, paused); end
      end
    end
    total++;
    if (cyc != 38) begin bad++; $display("FAIL pause_length: got %0d expected 38", cyc); end
  endtask

  task automatic test_abort();
    int cyc = 0;
    step(1, 2, 0, 0);
    while (!(phase === 3'd3 && pass_idx === 2'd1) && cyc < LIMIT) begin step(0, 2, 0, 0); cyc++; end
    step(0, 2, 0, 0);
    step(0, 2, 0, 1);
    total++;
    if (obs !== 8'h00 || obs !== exp_vec()) begin bad++; $display("FAIL abort_rinse2: got %h expected %h", obs, 8'h00); end
    step(1, 3, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 3, 0, 0);
    step(0, 3, 1, 1);
    total++;
    if (obs !== 8'h00) begin bad++; $display("FAIL abort_with_pause: got %h expected %h", obs, 8'h00); end
    step(1, 1, 0, 1);
    total++;
    if (obs !== 8'h00) begin bad++; $display("FAIL abort_blocks_start: got %h expected %h", obs, 8'h00); end
  endtask

  task automatic test_reset_mid_spin();
    int cyc = 0;
    step(1, 1, 0, 0);
    while (phase !== 3'd4 && cyc < LIMIT) begin step(0, 1, 0, 0); cyc++; end
    step(0, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1 model_reset();
    total++;
    if (obs !== 8'h00) begin bad++; $display("FAIL reset_mid_spin: got %h expected %h", obs, 8'h00); end
    step(1, 1, 0, 0);
    total++;
    if (obs !== 8'h00) begin bad++; $display("FAIL reset_held: got %h expected %h", obs, 8'h00); end
    #3 rst_n = 1'b1;
    cyc = 0;
    step(1, 1, 0, 0);
    while (busy === 1'b1 && cyc < LIMIT) begin
      step(0, 1, 0, 0); cyc++;
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL post_reset_cycle%0d: got %h expected %h", cyc, obs, exp_vec()); end
    end
    total++;
    if (cyc != 32 || wash_done !== 1'b1) begin bad++; $display("FAIL post_reset_length: got %0d expected 32", cyc); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int cyc = 0;
      int np = 0;
      int want;
      bit ab = 0;
      logic p, a;
      logic [PW-1:0] wp0 = PW'($urandom_range(0, 3));
      step(1, wp0, 0, 0);
      want = TD * (FS + SS + m_passes * (WS + RS));
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL rand%0d_start: got %h expected %h", r, obs, exp_vec()); end
      while (busy === 1'b1 && cyc < LIMIT) begin
        p = ($urandom_range(0, 7) == 0);
        a = ($urandom_range(0, 149) == 0);
        if (a) ab = 1;
        else if (p) np++;
        step(1'($urandom_range(0, 1)), PW'($urandom_range(0, 3)), p, a); cyc++;
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL rand%0d_cycle%0d: got %h expected %h", r, cyc, obs, exp_vec()); end
      end
      if (cyc >= LIMIT) begin
        total++; bad++; $display("FAIL rand%0d_timeout: got %0d cycles expected < %0d", r, cyc, LIMIT);
      end else if (!ab) begin
        total++;
        if (cyc != want + np) begin bad++; $display("FAIL rand%0d_length: got %0d expected %0d", r, cyc, want + np); end
      end
      step(0, 0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi();
    test_clamp();
    test_pause();
    test_abort();
    test_reset_mid_spin();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
